pipe_seg_elastic: RTL
=====================

# pipe_seg_elastic

Parametrised elastic pipeline segment register, the next generation of the fixed ID/EX segment register. It replaces the en/clear pair with a valid/ready handshake and an internal two-entry skid buffer, so a downstream stall no longer has to be broadcast combinationally upstream. It carries an arbitrary data payload plus a control payload that is forced to zero whenever the slot is a bubble. It sits between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and also provides a flush and a saturating bubble counter for performance monitoring.

## Interface
- DATA_W, 32*7, width of data payload (PC, NPC, imm, operands, etc.)
- CTRL_W, 24, width of control payload (RegWrite, MemWrite, AluContrl, BranchType, etc.)
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single entry with combinational in_ready
- CLEAR_DATA, 0, 1 = data payload is also zeroed on flush/reset; 0 = only valid and ctrl are zeroed
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  segment accepts this cycle
- in_data  in  DATA_W  upstream data payload
- in_ctrl  in  CTRL_W  upstream control payload
- flush  in  1  kill all held entries and the entry offered this cycle
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes head
- out_data  out  DATA_W  head data
- out_ctrl  out  CTRL_W  head control; all zero when out_valid=0
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0 and out_ready=1

## Operation
- Accept: in_valid & in_ready. Pop: out_valid & out_ready.
- States (SKID=1): EMPTY, ONE, FULL. The head register drives the outputs; the skid register holds the overflow entry.
- EMPTY: accept -> ONE, entry written to head.
- ONE: accept & pop -> ONE, head replaced. Accept & no pop -> FULL, entry written to skid. Pop & no accept -> EMPTY.
- FULL: in_ready=0. Pop -> ONE, skid moves to head. No pop -> FULL.
- SKID=0: single state bit. in_ready = ~out_valid | out_ready. Accept & pop in the same cycle replaces the head.
- Flush has priority over everything. The next state is EMPTY, and the input offered in the flush cycle is discarded even if in_ready=1. Any pop in the flush cycle still completes, because downstream sampled it.
- Bubble: whenever out_valid=0, out_ctrl=0, so downstream write enables are never spuriously asserted. out_data=0 only if CLEAR_DATA=1; otherwise it holds the last value.
- bubble_cnt increments by 1 per bubble cycle, saturates at all-ones, and does not wrap. It is unaffected by flush and cleared only by reset.
- in_data and in_ctrl are don't-care when in_valid=0 and must never be captured.

## Timing
- Latency: 1 cycle from accept to out_valid, whether the entry lands in EMPTY or in ONE with a simultaneous pop.
- Throughput: 1 entry per cycle sustained while out_ready=1.
- With SKID=1, in_ready is a pure register output: in_ready = (state != FULL). It has no combinational path from out_ready.
- Reset (rst_n=0 at a clk edge) sets: state EMPTY, out_valid=0, out_ctrl=0, occupancy=0, bubble_cnt=0, in_ready=1, out_data=0 (both CLEAR_DATA modes). Reset beats flush.
- Reset asserted mid-stream drops all held entries; nothing is replayed.
- Flush at cycle N: out_valid=0 at N+1, and a new accept is possible at N+1.
- out_valid, out_data, out_ctrl and occupancy are all registered.

## Structure
- Shared package pipe_pkg: the seg_state_e enum (EMPTY, ONE, FULL), and localparams for the standard ID/EX CTRL_W field offsets (RegWrite[2:0], MemToReg, MemWrite[3:0], LoadNpc, RegRead[1:0], BranchType[2:0], AluContrl[4:0], AluSrc1, AluSrc2[1:0], Jalr, BTB hit). Stage wrappers pack and unpack fields using these offsets.
- One sub-module: pipe_sat_counter (parametrised width, inc, sync active-low clear, saturating), reused later for stall and flush counters.

## Test plan
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0, bubble_cnt=0, in_ready=1.
- Streaming: 8 entries of data 0x100..0x107 with out_ready=1 -> each appears exactly 1 cycle after accept, in order, with no gaps.
- Backpressure: out_ready=0 after entry A, then offer B and C -> B is held in skid, occupancy=2, in_ready=0, C is stalled. Raise out_ready -> A, B, C emerge in order, none lost or duplicated.
- Flush in FULL, with entry D offered and out_ready=1 -> the head pop completes, D is discarded, and the next cycle shows out_valid=0, occupancy=0, in_ready=1.
- Bubble ctrl: CLEAR_DATA=0, ctrl=0xFFFFFF followed by an idle cycle -> out_ctrl=0 while out_data holds its last value. With CLEAR_DATA=1 -> out_data=0.
- Counter saturation: CNT_W=4, 20 bubble cycles with out_ready=1 -> bubble_cnt=15 and stays there. Reset -> 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline package: segment state encoding and the
// standard ID/EX control-payload field offsets used by stage wrappers.
package pipe_pkg;

    // Encoding doubles as the entry count held by the segment.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } seg_state_e;

    localparam int CTRL_W_STD    = 24;

    localparam int REG_WRITE_LSB = 0;
    localparam int REG_WRITE_W   = 3;
    localparam int MEM_TO_REG    = 3;
    localparam int MEM_WRITE_LSB = 4;
    localparam int MEM_WRITE_W   = 4;
    localparam int LOAD_NPC      = 8;
    localparam int REG_READ_LSB  = 9;
    localparam int REG_READ_W    = 2;
    localparam int BRANCH_LSB    = 11;
    localparam int BRANCH_W      = 3;
    localparam int ALU_CTRL_LSB  = 14;
    localparam int ALU_CTRL_W    = 5;
    localparam int ALU_SRC1      = 19;
    localparam int ALU_SRC2_LSB  = 20;
    localparam int ALU_SRC2_W    = 2;
    localparam int JALR          = 22;
    localparam int BTB_HIT       = 23;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Ports: clk, clr_n (sync clear), inc (count enable), count (value).
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_seg_elastic.sv
// Elastic pipeline segment: valid/ready register slice with optional skid
// entry, flush, bubble-zeroed control and a saturating bubble counter.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data/in_ctrl
// upstream; out_valid/out_ready/out_data/out_ctrl downstream; flush;
// occupancy (entries held); bubble_cnt (out_valid=0 & out_ready=1 cycles).
module pipe_seg_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32*7,
    parameter int CTRL_W     = 24,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    seg_state_e        state;
    seg_state_e        state_nxt;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              pop;
    logic              load_in;
    logic              load_skid;
    logic              move_skid;

    assign out_valid = (state != EMPTY);
    assign out_data  = head_data;
    assign out_ctrl  = head_ctrl;
    assign occupancy = 2'(state);

    // With a skid entry, in_ready depends only on the state register.
    assign in_ready = (SKID != 0) ? (state != FULL)
                                  : (~out_valid | out_ready);

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        load_in   = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        load_in   = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_in = 1'b1;
                    end else if (accept && (SKID != 0)) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt = ONE;
                        move_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            head_data <= '0;
            head_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state <= state_nxt;
            if (load_in) begin
                head_data <= in_data;
                head_ctrl <= in_ctrl;
            end
            if (move_skid) begin
                head_data <= skid_data;
                head_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
            // A bubble must never present live control bits downstream.
            if (state_nxt == EMPTY) begin
                head_ctrl <= '0;
                if (CLEAR_DATA != 0) begin
                    head_data <= '0;
                end
            end
        end
    end

    pipe_sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (~out_valid & out_ready),
        .count (bubble_cnt)
    );

endmodule
